// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared types and constants for the multicycle MIPS control
//               unit: FSM state enum, opcode/funct codes, ALUControl codes,
//               ALUSrcB mux codes and the internal ALUOp class.
//               The HALT state exists only when ILLEGAL_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

   // Opcodes (Instr[31:26])
   localparam logic [5:0] c_OP_RTYPE = 6'h00;
   localparam logic [5:0] c_OP_LW    = 6'h23;
   localparam logic [5:0] c_OP_SW    = 6'h2B;
   localparam logic [5:0] c_OP_BEQ   = 6'h04;
   localparam logic [5:0] c_OP_BNE   = 6'h05;
   localparam logic [5:0] c_OP_ADDI  = 6'h08;

   // R-type function fields (Instr[5:0])
   localparam logic [5:0] c_FUNCT_ADD = 6'h20;
   localparam logic [5:0] c_FUNCT_SUB = 6'h22;
   localparam logic [5:0] c_FUNCT_AND = 6'h24;
   localparam logic [5:0] c_FUNCT_OR  = 6'h25;
   localparam logic [5:0] c_FUNCT_NOR = 6'h27;
   localparam logic [5:0] c_FUNCT_SLT = 6'h2A;

   // ALUControl codes
   localparam logic [3:0] c_ALU_AND = 4'b0000;
   localparam logic [3:0] c_ALU_OR  = 4'b0001;
   localparam logic [3:0] c_ALU_ADD = 4'b0010;
   localparam logic [3:0] c_ALU_SUB = 4'b0110;
   localparam logic [3:0] c_ALU_SLT = 4'b0111;
   localparam logic [3:0] c_ALU_NOR = 4'b1100;

   // ALUSrcB mux select codes
   localparam logic [1:0] c_SRCB_B       = 2'b00;
   localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
   localparam logic [1:0] c_SRCB_IMM     = 2'b10;
   localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

   // FSM states
   typedef enum logic [3:0] {
      INIT     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMRD    = 4'd4,
      MEMWB    = 4'd5,
      MEMWR    = 4'd6,
      RTYPE_EX = 4'd7,
      RTYPE_WB = 4'd8,
      BRANCH   = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11
`ifdef ILLEGAL_TRAP_EN
      ,
      HALT     = 4'd12
`endif
   } state_e;

   // ALU operation class derived from the current state; NONE yields the
   // all-zero ALUControl used in states that do not drive the ALU.
   typedef enum logic [1:0] {
      ALUOP_NONE  = 2'b00,
      ALUOP_ADD   = 2'b01,
      ALUOP_SUB   = 2'b10,
      ALUOP_FUNCT = 2'b11
   } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_if
// Description : Bundle between the control unit and the multicycle datapath.
//               master : control unit (consumes OP/Funct/Zero, drives controls)
//               slave  : datapath side (drives OP/Funct/Zero, consumes controls)
//               Signals: OP, Funct, Zero, initial_sel, PCWrite, IorD,
//               MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCSrc,
//               ALUSrcA, ALUSrcB[1:0], ALUControl[3:0], state_o[3:0],
//               halted_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6
);
   logic [OP_W-1:0]    OP;
   logic [FUNCT_W-1:0] Funct;
   logic               Zero;

   logic               initial_sel;
   logic               PCWrite;
   logic               IorD;
   logic               MemWrite;
   logic               IRWrite;
   logic               RegDst;
   logic               MemtoReg;
   logic               RegWrite;
   logic               PCSrc;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [3:0]         ALUControl;
   logic [3:0]         state_o;
   logic               halted_o;

   modport master (
      input  OP, Funct, Zero,
      output initial_sel, PCWrite, IorD, MemWrite, IRWrite, RegDst,
             MemtoReg, RegWrite, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
             state_o, halted_o
   );

   modport slave (
      output OP, Funct, Zero,
      input  initial_sel, PCWrite, IorD, MemWrite, IRWrite, RegDst,
             MemtoReg, RegWrite, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
             state_o, halted_o
   );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational ALU decoder. Maps the state-derived ALUOp and
//               the instruction Funct field to ALUControl and a funct_legal
//               flag. An unknown Funct under ALUOP_FUNCT yields ADD and
//               funct_legal=0 so the FSM can discard the instruction.
//   alu_op_i      : ALU operation class from the FSM
//   funct_i       : Instr[5:0]
//   alu_control_o : ALUControl code
//   funct_legal_o : 0 only for an unrecognised R-type Funct
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int FUNCT_W = 6
) (
   input  alu_op_e            alu_op_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output logic [3:0]         alu_control_o,
   output logic               funct_legal_o
);

   always_comb begin
      alu_control_o = c_ALU_AND;
      funct_legal_o = 1'b1;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = c_ALU_ADD;
         ALUOP_SUB: alu_control_o = c_ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               FUNCT_W'(c_FUNCT_ADD): alu_control_o = c_ALU_ADD;
               FUNCT_W'(c_FUNCT_SUB): alu_control_o = c_ALU_SUB;
               FUNCT_W'(c_FUNCT_AND): alu_control_o = c_ALU_AND;
               FUNCT_W'(c_FUNCT_OR):  alu_control_o = c_ALU_OR;
               FUNCT_W'(c_FUNCT_NOR): alu_control_o = c_ALU_NOR;
               FUNCT_W'(c_FUNCT_SLT): alu_control_o = c_ALU_SLT;
               default: begin
                  // Unknown (or X) funct: harmless ADD, flagged illegal
                  alu_control_o = c_ALU_ADD;
                  funct_legal_o = 1'b0;
               end
            endcase
         end
         default: alu_control_o = c_ALU_AND;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Moore FSM sequencing the multicycle MIPS datapath (lw, sw,
//               R-type add/sub/and/or/slt/nor, beq, bne, addi). Outputs are
//               decoded from the state register only, except PCWrite in
//               BRANCH which also follows the live Zero flag.
//               Build option ILLEGAL_TRAP_EN: when defined, an illegal
//               opcode/funct traps into a sticky HALT state (halted_o=1);
//               when undefined, illegal instructions retire as NOPs.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : control/datapath bundle (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int FUNCT_W = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   multicycle_control_unit_if.master  bus
);

`ifdef ILLEGAL_TRAP_EN
   localparam state_e c_ILLEGAL_NEXT = HALT;
`else
   localparam state_e c_ILLEGAL_NEXT = FETCH;
`endif

   state_e     state_q;
   state_e     state_d;
   alu_op_e    w_alu_op;
   logic [3:0] w_alu_control;
   logic       w_funct_legal;

   // ------------------------------------------------------------------
   // State register: the async reset forces INIT, and with it every
   // write enable low, in the same instant reset falls.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:   state_d = FETCH;
         FETCH:  state_d = DECODE;
         DECODE: begin
            // X or unknown opcodes fall through to the default arm
            case (bus.OP)
               OP_W'(c_OP_LW),
               OP_W'(c_OP_SW):    state_d = MEMADR;
               OP_W'(c_OP_RTYPE): state_d = RTYPE_EX;
               OP_W'(c_OP_BEQ),
               OP_W'(c_OP_BNE):   state_d = BRANCH;
               OP_W'(c_OP_ADDI):  state_d = ADDI_EX;
               default:           state_d = c_ILLEGAL_NEXT;
            endcase
         end
         MEMADR:   state_d = (bus.OP == OP_W'(c_OP_SW)) ? MEMWR : MEMRD;
         MEMRD:    state_d = MEMWB;
         MEMWB:    state_d = FETCH;
         MEMWR:    state_d = FETCH;
         // An illegal funct skips write-back entirely
         RTYPE_EX: state_d = w_funct_legal ? RTYPE_WB : c_ILLEGAL_NEXT;
         RTYPE_WB: state_d = FETCH;
         BRANCH:   state_d = FETCH;
         ADDI_EX:  state_d = ADDI_WB;
         ADDI_WB:  state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
         HALT:     state_d = HALT;
`endif
         default:  state_d = INIT;
      endcase
   end

   // ------------------------------------------------------------------
   // ALU operation class per state, resolved by the ALU decoder
   // ------------------------------------------------------------------
   always_comb begin
      w_alu_op = ALUOP_NONE;
      case (state_q)
         FETCH, DECODE, MEMADR, ADDI_EX: w_alu_op = ALUOP_ADD;
         BRANCH:                         w_alu_op = ALUOP_SUB;
         RTYPE_EX:                       w_alu_op = ALUOP_FUNCT;
         default:                        w_alu_op = ALUOP_NONE;
      endcase
   end

   alu_decoder #(
      .FUNCT_W (FUNCT_W)
   ) u_alu_decoder (
      .alu_op_i      (w_alu_op),
      .funct_i       (bus.Funct),
      .alu_control_o (w_alu_control),
      .funct_legal_o (w_funct_legal)
   );

   // ------------------------------------------------------------------
   // Output decoder: everything defaults to 0 and each state raises only
   // the controls it needs.
   // ------------------------------------------------------------------
   always_comb begin
      bus.initial_sel = 1'b0;
      bus.PCWrite     = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegDst      = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.PCSrc       = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = c_SRCB_B;
      case (state_q)
         INIT: bus.initial_sel = 1'b1;
         FETCH: begin
            bus.IRWrite = 1'b1;
            bus.ALUSrcB = c_SRCB_FOUR;
            bus.PCWrite = 1'b1;
         end
         // Branch target is precomputed into ALUOut here
         DECODE: bus.ALUSrcB = c_SRCB_IMM_SH2;
         MEMADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = c_SRCB_IMM;
         end
         MEMRD: bus.IorD = 1'b1;
         MEMWB: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = 1'b1;
         end
         MEMWR: begin
            bus.IorD     = 1'b1;
            bus.MemWrite = 1'b1;
         end
         RTYPE_EX: bus.ALUSrcA = 1'b1;
         RTYPE_WB: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
         end
         BRANCH: begin
            bus.ALUSrcA = 1'b1;
            bus.PCSrc   = 1'b1;
            // Only Mealy-style term: taken decision follows live Zero
            bus.PCWrite = (bus.OP == OP_W'(c_OP_BNE)) ? ~bus.Zero : bus.Zero;
         end
         ADDI_EX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = c_SRCB_IMM;
         end
         ADDI_WB: bus.RegWrite = 1'b1;
         default: ;
      endcase
   end

   assign bus.ALUControl = w_alu_control;
   assign bus.state_o    = state_q;

`ifdef ILLEGAL_TRAP_EN
   assign bus.halted_o = (state_q == HALT);
`else
   assign bus.halted_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. Each
//               instruction is summarised (latency, write-enable counts,
//               mux usage, ALU code, write-back flags) and compared against
//               table constants or an instruction-level reference model.
//               Honours ILLEGAL_TRAP_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;
   import mips_ctrl_pkg::*;

   typedef struct packed {
      logic [7:0] cycles;
      logic [3:0] rw;
      logic [3:0] mw;
      logic [3:0] pw;
      logic [3:0] iord;
      logic [3:0] srca;
      logic [3:0] pcsrc;
      logic [3:0] irw;
      logic [3:0] init;
      logic [7:0] srcb;
      logic [3:0] alu;
      logic [1:0] wb;
   } summ_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      summ_t      exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   multicycle_control_unit_if #(.OP_W(6), .FUNCT_W(6)) bus ();

   multicycle_control_unit #(.OP_W(6), .FUNCT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic string fmt(summ_t s);
      return $sformatf("cyc=%0d rw=%0d mw=%0d pw=%0d iord=%0d srca=%0d pcsrc=%0d irw=%0d init=%0d srcb=%0d alu=%h wb=%b",
                       s.cycles, s.rw, s.mw, s.pw, s.iord, s.srca, s.pcsrc, s.irw, s.init, s.srcb, s.alu, s.wb);
   endfunction

   function automatic summ_t mk(int cyc, int rw, int mw, int pw, int iord, int srcb,
                                int srca, int pcsrc, logic [3:0] alu, logic [1:0] wb);
      summ_t s;
      s.cycles = 8'(cyc); s.rw = 4'(rw); s.mw = 4'(mw); s.pw = 4'(pw);
      s.iord = 4'(iord); s.srcb = 8'(srcb); s.srca = 4'(srca); s.pcsrc = 4'(pcsrc);
      s.irw = 4'd1; s.init = 4'd0; s.alu = alu; s.wb = wb;
      return s;
   endfunction

   // Instruction-level reference: what one instruction does to the datapath
   function automatic summ_t model(logic [5:0] op, logic [5:0] funct, logic zero);
      summ_t s;
      s = mk(2, 0, 0, 1, 0, 4, 0, 0, 4'hF, 2'b11);   // fetch + decode only
      case (op)
         6'h23: begin s.cycles = 5; s.rw = 1; s.wb = 2'b01; s.iord = 1; s.srcb = 6; s.srca = 1; s.alu = 4'h2; end
         6'h2B: begin s.cycles = 4; s.mw = 1; s.iord = 1; s.srcb = 6; s.srca = 1; s.alu = 4'h2; end
         6'h08: begin s.cycles = 4; s.rw = 1; s.wb = 2'b00; s.srcb = 6; s.srca = 1; s.alu = 4'h2; end
         6'h04, 6'h05: begin
            s.cycles = 3; s.srca = 1; s.pcsrc = 1; s.alu = 4'h6;
            if ((op == 6'h04) ? zero : !zero) s.pw = 2;
         end
         6'h00: begin
            s.srca = 1;
            s.cycles = 4; s.rw = 1; s.wb = 2'b10;
            case (funct)
               6'h20: s.alu = 4'h2;
               6'h22: s.alu = 4'h6;
               6'h24: s.alu = 4'h0;
               6'h25: s.alu = 4'h1;
               6'h27: s.alu = 4'hC;
               6'h2A: s.alu = 4'h7;
               default: begin s.cycles = 3; s.rw = 0; s.wb = 2'b11; s.alu = 4'h2; end
            endcase
         end
         default: ;
      endcase
      return s;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic chk_summ(string name, summ_t act, summ_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got {%s} required {%s}", name, fmt(act), fmt(exp));
      end
   endtask

   function automatic logic [3:0] enables();
      return {bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite};
   endfunction

   function automatic logic [16:0] all_outs();
      return {bus.initial_sel, bus.PCWrite, bus.IorD, bus.MemWrite, bus.IRWrite,
              bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.PCSrc, bus.ALUSrcA,
              bus.ALUSrcB, bus.ALUControl, bus.halted_o};
   endfunction

   // Assert reset for 3 cycles, release, and finish at FETCH (negedge+1)
   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_state_async", 32'(bus.state_o), 32'(INIT));
      chk("rst_enables_async", 32'(enables()), 0);
      repeat (3) begin
         @(negedge clk); #1;
         chk("rst_state", 32'(bus.state_o), 32'(INIT));
         chk("rst_enables", 32'(enables()), 0);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel_cycle1_initial_sel", 32'(bus.initial_sel), 1);
      @(negedge clk); #1;
      chk("rel_cycle2_fetch", 32'({bus.state_o, bus.IRWrite, bus.PCWrite, bus.ALUSrcB, bus.initial_sel}),
          32'({4'(FETCH), 1'b1, 1'b1, 2'b01, 1'b0}));
   endtask

   // Run one instruction starting in FETCH, return its summary
   task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                            input logic zero, output summ_t s);
      int  c;
      bit  done;
      s = '0; s.alu = 4'hF; s.wb = 2'b11;
      c = 0; done = 0;
      bus.OP = op; bus.Funct = funct; bus.Zero = zero;
      #1;
      while (!done) begin
         s.rw    = s.rw + 4'(bus.RegWrite);
         s.mw    = s.mw + 4'(bus.MemWrite);
         s.pw    = s.pw + 4'(bus.PCWrite);
         s.iord  = s.iord + 4'(bus.IorD);
         s.srca  = s.srca + 4'(bus.ALUSrcA);
         s.pcsrc = s.pcsrc + 4'(bus.PCSrc);
         s.irw   = s.irw + 4'(bus.IRWrite);
         s.init  = s.init + 4'(bus.initial_sel);
         s.srcb  = s.srcb + 8'(bus.ALUSrcB);
         if (bus.ALUSrcA)  s.alu = bus.ALUControl;
         if (bus.RegWrite) s.wb = {bus.RegDst, bus.MemtoReg};
         c++;
         @(negedge clk); #1;
         if (bus.state_o == 4'(FETCH)) begin
            done = 1;
         end else if (c >= 12) begin
            n_cmp++; n_bad++;
            $display("FAIL instr_timeout: got no FETCH after %0d cycles required at most 5", c);
            done = 1;
         end
      end
      s.cycles = 8'(c);
   endtask

   initial begin
      vec_t  vecs[$];
      summ_t s, s2;
      state_e lw_path[6];
      logic [5:0] ops[8];
      logic [5:0] fns[6];

      reset = 1'b0; bus.OP = '0; bus.Funct = '0; bus.Zero = 1'b0;

      vecs.push_back('{6'h23, 6'h00, 1'b0, mk(5, 1, 0, 1, 1, 6, 1, 0, 4'h2, 2'b01)});
      vecs.push_back('{6'h2B, 6'h00, 1'b0, mk(4, 0, 1, 1, 1, 6, 1, 0, 4'h2, 2'b11)});
      vecs.push_back('{6'h00, 6'h20, 1'b0, mk(4, 1, 0, 1, 0, 4, 1, 0, 4'h2, 2'b10)});
      vecs.push_back('{6'h00, 6'h22, 1'b1, mk(4, 1, 0, 1, 0, 4, 1, 0, 4'h6, 2'b10)});
      vecs.push_back('{6'h00, 6'h24, 1'b0, mk(4, 1, 0, 1, 0, 4, 1, 0, 4'h0, 2'b10)});
      vecs.push_back('{6'h00, 6'h25, 1'b0, mk(4, 1, 0, 1, 0, 4, 1, 0, 4'h1, 2'b10)});
      vecs.push_back('{6'h00, 6'h27, 1'b0, mk(4, 1, 0, 1, 0, 4, 1, 0, 4'hC, 2'b10)});
      vecs.push_back('{6'h00, 6'h2A, 1'b0, mk(4, 1, 0, 1, 0, 4, 1, 0, 4'h7, 2'b10)});
      vecs.push_back('{6'h04, 6'h00, 1'b1, mk(3, 0, 0, 2, 0, 4, 1, 1, 4'h6, 2'b11)});
      vecs.push_back('{6'h04, 6'h00, 1'b0, mk(3, 0, 0, 1, 0, 4, 1, 1, 4'h6, 2'b11)});
      vecs.push_back('{6'h05, 6'h00, 1'b0, mk(3, 0, 0, 2, 0, 4, 1, 1, 4'h6, 2'b11)});
      vecs.push_back('{6'h05, 6'h00, 1'b1, mk(3, 0, 0, 1, 0, 4, 1, 1, 4'h6, 2'b11)});
      vecs.push_back('{6'h08, 6'h3F, 1'b1, mk(4, 1, 0, 1, 0, 6, 1, 0, 4'h2, 2'b00)});
`ifndef ILLEGAL_TRAP_EN
      vecs.push_back('{6'h3F, 6'h20, 1'b0, mk(2, 0, 0, 1, 0, 4, 0, 0, 4'hF, 2'b11)});
      vecs.push_back('{6'h00, 6'h3F, 1'b0, mk(3, 0, 0, 1, 0, 4, 1, 0, 4'h2, 2'b11)});
`endif

      do_reset();

      // ---------------- table-driven vectors ----------------
      foreach (vecs[i]) begin
         run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, s);
         chk_summ($sformatf("vec%0d_op%h_fn%h_z%0d", i, vecs[i].op, vecs[i].funct, vecs[i].zero), s, vecs[i].exp);
      end

      // ---------------- lw state path ----------------
      lw_path = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH};
      bus.OP = 6'h23; bus.Funct = 6'h00;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("lw_path_state%0d", i), 32'(bus.state_o), 32'(lw_path[i]));
         chk($sformatf("lw_path_memtoreg%0d", i), 32'({bus.MemtoReg, bus.RegWrite}), (i == 4) ? 32'h3 : 32'h0);
         if (i < 5) begin @(negedge clk); #1; end
      end

      // ---------------- sw then addi back-to-back ----------------
      run_instr(6'h2B, 6'h00, 1'b0, s);
      run_instr(6'h08, 6'h00, 1'b0, s2);
      chk("sw_addi_total_cycles", 32'(s.cycles) + 32'(s2.cycles), 8);
      chk("sw_memwrite_once", 32'(s.mw), 1);

      // ---------------- illegal opcode 0x3F ----------------
`ifdef ILLEGAL_TRAP_EN
      bus.OP = 6'h3F;
      @(negedge clk); #1;
      chk("ill_decode_state", 32'(bus.state_o), 32'(DECODE));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         bus.OP = 6'(i);            // nothing but reset may leave HALT
         chk($sformatf("halt_state%0d", i), 32'(bus.state_o), 32'(HALT));
         chk($sformatf("halt_outs%0d", i), 32'(all_outs()), 32'h1);
      end
      do_reset();
`else
      bus.OP = 6'h3F;
      @(negedge clk); #1;
      chk("ill_decode_state", 32'(bus.state_o), 32'(DECODE));
      @(negedge clk); #1;
      chk("ill_next_fetch", 32'(bus.state_o), 32'(FETCH));
      chk("ill_halted_zero", 32'(bus.halted_o), 0);
`endif

      // ---------------- reset mid-MEMRD ----------------
      bus.OP = 6'h23;
      @(negedge clk); #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("memrd_reached", 32'({bus.state_o, bus.IorD}), 32'({4'(MEMRD), 1'b1}));
      #2 reset = 1'b0;
      #1;
      chk("midrd_async_state", 32'(bus.state_o), 32'(INIT));
      chk("midrd_async_outs", 32'({enables(), bus.IorD}), 0);
      @(negedge clk); #1;
      chk("midrd_no_writeback", 32'({bus.state_o, bus.RegWrite}), 32'({4'(INIT), 1'b0}));
      do_reset();

      // ---------------- randomized against reference model ----------------
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h3F, 6'h11};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      for (int n = 0; n < 200; n++) begin
         logic [5:0] op, fn;
         logic       z;
`ifdef ILLEGAL_TRAP_EN
         op = ops[$urandom_range(0, 5)];
         fn = fns[$urandom_range(0, 5)];
`else
         op = ops[$urandom_range(0, 7)];
         if (op == 6'h11) op = 6'($urandom_range(0, 63));
         fn = $urandom_range(0, 1) ? fns[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
`endif
         z = 1'($urandom_range(0, 1));
         run_instr(op, fn, z, s);
         chk_summ($sformatf("rand%0d_op%h_fn%h_z%0d", n, op, fn, z), s, model(op, fn, z));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
